call_scheduler: RTL and testbench
=================================

# call_scheduler

Upstream request stage for `elevator`. Latches floor-call button presses, picks the next floor to serve with a SCAN (keep-direction) policy, and drives the elevator's `in` (target floor) and `stop` (door dwell) inputs. It watches the elevator's `floor` output to detect arrival. One instance per car; its outputs connect directly to `elevator`.

## Interface
- `FLOORS`, 4: number of floors; fixed to 2^FLOOR_W.
- `FLOOR_W`, 2: floor index width; matches `elevator.floor` and `elevator.in`.
- `DWELL_CYCLES`, 3: cycles `stop` stays high per served call; range 1..15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `call` in FLOORS: one bit per floor, level or pulse; sampled every edge.
- `floor` in FLOOR_W: current floor, from `elevator.floor`.
- `target` out FLOOR_W: next floor; drives `elevator.in`.
- `stop` out 1: door dwell; drives `elevator.stop`.
- `pending` out FLOORS: latched unserved calls.
- `dir_up` out 1: current or last travel direction (1 = up).
- `busy` out 1: high when state is not IDLE.
- `served_count` out 8: number of calls served; saturates at 255.

## Operation
- Reset values:
  - `target`=0, `stop`=0, `pending`=0, `dir_up`=1, `busy`=0, `served_count`=0.
  - State=IDLE, dwell counter=0.
- Pending update each edge: `pending <= (pending | call) & ~clr`.
  - `clr` is one-hot at `floor` on the edge that enters DWELL.
  - During DWELL, `call[floor]` is masked (absorbed by the open door).
  - A call at any other floor is latched normally.
- Search (combinational):
  - `above` = lowest pending index > `floor`.
  - `below` = highest pending index < `floor`.
  - `any_above` and `any_below` flags.
- IDLE:
  - If `pending[floor]`, go to DWELL.
  - Else if there is a pending call in the `dir_up` direction, keep `dir_up` and move that way.
  - Else if there is one in the opposite direction, flip `dir_up` and move.
  - Else stay IDLE with `target`=`floor`.
- MOVE_UP:
  - `target` <= `above`, re-evaluated every cycle, so a newer call between the car and the old target retargets to the nearer one.
  - If `pending[floor]`, go to DWELL.
- MOVE_DOWN: mirror of MOVE_UP, using `below`.
- DWELL:
  - `stop`=1 and `target`=`floor`.
  - The counter loads DWELL_CYCLES-1 on entry and decrements each cycle.
  - At 0: continue in `dir_up` if calls remain that way, else reverse, else go to IDLE.
- `served_count` increments on each DWELL entry; it holds at 255 once reached.
- `busy` = (state != IDLE).
- All outputs are registered.

## Timing
- `call[k]` high before edge N: `pending[k]`=1 after edge N.
- `target` reflects it after edge N+1 (two-edge latency).
- Arrival: `floor`==pending floor before edge M.
  - DWELL is entered at edge M: `stop`=1 and `pending` bit cleared after M.
  - `stop` stays high for exactly DWELL_CYCLES cycles, then drops at the transition out of DWELL.
- Simultaneous calls above and below while IDLE: `dir_up` wins; after reset this is up.
- Call at the current floor while IDLE: DWELL at the next edge, and the car does not move.
- `floor` outside the range 0..FLOORS-1 cannot occur, since all codes are valid.
- Reset asserted mid-move or mid-dwell: all outputs return to their reset values immediately, without waiting for a clock edge. The first action after release is on the next edge.

## Structure
- Package `elevator_pkg`:
  - `FLOOR_W`, `FLOORS`.
  - State enum IDLE / MOVE_UP / MOVE_DOWN / DWELL.
  - Width of `served_count`.
- Sub-module `pending_search`:
  - Purely combinational.
  - Inputs: `pending` and `floor`.
  - Outputs: `above`, `below`, `any_above`, `any_below`, `here`.
- Everything else (FSM, pending register, dwell counter, served counter) lives in `call_scheduler`.

## Test plan
- Reset with `floor`=0, then `call`=4'b1000 for 1 cycle:
  - `pending`=1000, then `target`=3, `dir_up`=1.
  - When `floor`=3: `stop` high 3 cycles, `pending`=0, `served_count`=1, then IDLE.
- Car at floor 1, calls at floors 0 and 3 in the same cycle, `dir_up`=1:
  - Serves 3 first, then `target`=0 and `dir_up`=0.
  - `served_count`=2 at the end.
- Moving up to 3 from floor 0, call at floor 2 arrives while `floor`=1:
  - `target` changes 3→2.
  - Dwell at 2, then resume to 3.
- IDLE at floor 2 with `call[2]` pulsed:
  - DWELL at the next edge, `target` stays 2, 3 cycles of `stop`.
  - `call[2]` held through the dwell does not re-latch.
- Assert `reset` for 1 cycle in the middle of a dwell:
  - `stop`, `pending`, `served_count` go to 0 asynchronously; state is IDLE.
- 300 single-floor calls served back to back: `served_count` saturates at 255.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and sizes for the elevator call scheduler and its helpers.
package elevator_pkg;

    localparam int FLOOR_W  = 2;
    localparam int FLOORS   = 1 << FLOOR_W;
    localparam int SERVED_W = 8;

    localparam logic [SERVED_W-1:0] SERVED_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DWELL     = 2'd3
    } state_t;

endpackage

// File: rtl/pending_search.sv
// Combinational search of the pending-call vector relative to the car's floor:
// nearest call above, nearest call below, and whether the current floor is called.
module pending_search
    import elevator_pkg::*;
(
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] floor,
    output logic [FLOOR_W-1:0] above,
    output logic [FLOOR_W-1:0] below,
    output logic               any_above,
    output logic               any_below,
    output logic               here
);

    always_comb begin
        above     = '0;
        below     = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        here      = pending[floor];
        // Descending scan: the last hit above the car is the lowest one.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(floor))) begin
                above     = FLOOR_W'(i);
                any_above = 1'b1;
            end
        end
        // Ascending scan: the last hit below the car is the highest one.
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (i < int'(floor))) begin
                below     = FLOOR_W'(i);
                any_below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// SCAN call scheduler: latches floor calls, chooses the next target floor while
// keeping direction, and holds the door open for DWELL_CYCLES on each served call.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [FLOORS-1:0]   call,
    input  logic [FLOOR_W-1:0]  floor,
    output logic [FLOOR_W-1:0]  target,
    output logic                stop,
    output logic [FLOORS-1:0]   pending,
    output logic                dir_up,
    output logic                busy,
    output logic [SERVED_W-1:0] served_count,
    output state_t              state_dbg
);

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL_CYCLES - 1);

    state_t             state;
    logic [3:0]         dwell_cnt;
    logic [FLOOR_W-1:0] above;
    logic [FLOOR_W-1:0] below;
    logic               any_above;
    logic               any_below;
    logic               here;
    logic [FLOORS-1:0]  floor_hot;
    logic               enter_dwell;

    state_t             pick_state;
    logic               pick_dir;
    logic [FLOOR_W-1:0] pick_target;

    pending_search u_search (
        .pending   (pending),
        .floor     (floor),
        .above     (above),
        .below     (below),
        .any_above (any_above),
        .any_below (any_below),
        .here      (here)
    );

    assign state_dbg = state;
    assign floor_hot = FLOORS'(1) << floor;

    // A pending call at the car's floor opens the door, except while a dwell is still counting.
    assign enter_dwell = here && ((state != DWELL) || (dwell_cnt == 4'd0));

    // Direction choice used from IDLE, at the end of a dwell, and when a move runs out of calls.
    always_comb begin
        pick_state  = IDLE;
        pick_dir    = dir_up;
        pick_target = floor;
        if (dir_up && any_above) begin
            pick_state  = MOVE_UP;
            pick_target = above;
        end else if (!dir_up && any_below) begin
            pick_state  = MOVE_DOWN;
            pick_target = below;
        end else if (any_above) begin
            pick_state  = MOVE_UP;
            pick_dir    = 1'b1;
            pick_target = above;
        end else if (any_below) begin
            pick_state  = MOVE_DOWN;
            pick_dir    = 1'b0;
            pick_target = below;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            // The open door absorbs presses at its own floor.
            pending <= (pending | (call & ~((state == DWELL) ? floor_hot : '0)))
                       & ~(enter_dwell ? floor_hot : '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            target       <= '0;
            stop         <= 1'b0;
            dir_up       <= 1'b1;
            busy         <= 1'b0;
            served_count <= '0;
            dwell_cnt    <= '0;
        end else if (enter_dwell) begin
            state     <= DWELL;
            target    <= floor;
            stop      <= 1'b1;
            busy      <= 1'b1;
            dwell_cnt <= DWELL_LOAD;
            if (served_count != SERVED_MAX) begin
                served_count <= served_count + 1'b1;
            end
        end else begin
            case (state)
                MOVE_UP: begin
                    if (any_above) begin
                        target <= above;
                    end else begin
                        state  <= pick_state;
                        dir_up <= pick_dir;
                        target <= pick_target;
                        busy   <= (pick_state != IDLE);
                    end
                end
                MOVE_DOWN: begin
                    if (any_below) begin
                        target <= below;
                    end else begin
                        state  <= pick_state;
                        dir_up <= pick_dir;
                        target <= pick_target;
                        busy   <= (pick_state != IDLE);
                    end
                end
                DWELL: begin
                    if (dwell_cnt != 4'd0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                        target    <= floor;
                    end else begin
                        stop   <= 1'b0;
                        state  <= pick_state;
                        dir_up <= pick_dir;
                        target <= pick_target;
                        busy   <= (pick_state != IDLE);
                    end
                end
                default: begin
                    stop   <= 1'b0;
                    state  <= pick_state;
                    dir_up <= pick_dir;
                    target <= pick_target;
                    busy   <= (pick_state != IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler; the car's floor is driven by hand in place of an elevator.
module tb_call_scheduler;
    import elevator_pkg::*;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [FLOORS-1:0]   call  = '0;
    logic [FLOOR_W-1:0]  floor = '0;
    logic [FLOOR_W-1:0]  target;
    logic                stop;
    logic [FLOORS-1:0]   pending;
    logic                dir_up;
    logic                busy;
    logic [SERVED_W-1:0] served_count;
    state_t              state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    call_scheduler #(.DWELL_CYCLES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .call         (call),
        .floor        (floor),
        .target       (target),
        .stop         (stop),
        .pending      (pending),
        .dir_up       (dir_up),
        .busy         (busy),
        .served_count (served_count),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    // Advance n edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        call  = '0;
        floor = '0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (target !== 2'd0) begin tests_failed++; $display("FAIL reset_target: got %0d want 0", target); end
        tests_run++; if (stop !== 1'b0) begin tests_failed++; $display("FAIL reset_stop: got %b want 0", stop); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending: got %b want 0000", pending); end
        tests_run++; if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL reset_dir_up: got %b want 1", dir_up); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (served_count !== 8'd0) begin tests_failed++; $display("FAIL reset_served: got %0d want 0", served_count); end
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_single_call();
        do_reset();
        call = 4'b1000;
        step(1);
        tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL single_pending: got %b want 1000", pending); end
        tests_run++; if (target !== 2'd0) begin tests_failed++; $display("FAIL single_target_lat: got %0d want 0", target); end
        call = '0;
        step(1);
        tests_run++; if (target !== 2'd3) begin tests_failed++; $display("FAIL single_target: got %0d want 3", target); end
        tests_run++; if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL single_dir: got %b want 1", dir_up); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", busy); end
        tests_run++; if (state_dbg !== MOVE_UP) begin tests_failed++; $display("FAIL single_state: got %0d want MOVE_UP", state_dbg); end
        floor = 2'd1;
        step(1);
        tests_run++; if (target !== 2'd3) begin tests_failed++; $display("FAIL single_target_f1: got %0d want 3", target); end
        tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL single_pending_f1: got %b want 1000", pending); end
        floor = 2'd3;
        step(1);
        tests_run++; if (stop !== 1'b1) begin tests_failed++; $display("FAIL single_stop_entry: got %b want 1", stop); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL single_pending_clr: got %b want 0000", pending); end
        tests_run++; if (served_count !== 8'd1) begin tests_failed++; $display("FAIL single_served: got %0d want 1", served_count); end
        for (int k = 2; k <= 3; k++) begin
            step(1);
            tests_run++; if (stop !== 1'b1) begin tests_failed++; $display("FAIL single_stop_cycle%0d: got %b want 1", k, stop); end
        end
        step(1);
        tests_run++; if (stop !== 1'b0) begin tests_failed++; $display("FAIL single_stop_drop: got %b want 0", stop); end
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL single_idle: got %0d want IDLE", state_dbg); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end: got %b want 0", busy); end
        tests_run++; if (target !== 2'd3) begin tests_failed++; $display("FAIL single_target_end: got %0d want 3", target); end
    endtask

    task automatic test_scan_order();
        do_reset();
        floor = 2'd1;
        call  = 4'b1001;
        step(1);
        call = '0;
        step(1);
        tests_run++; if (target !== 2'd3) begin tests_failed++; $display("FAIL scan_first_target: got %0d want 3", target); end
        tests_run++; if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL scan_first_dir: got %b want 1", dir_up); end
        floor = 2'd2;
        step(1);
        floor = 2'd3;
        step(1);
        tests_run++; if (pending !== 4'b0001) begin tests_failed++; $display("FAIL scan_pending_mid: got %b want 0001", pending); end
        step(3);
        tests_run++; if (target !== 2'd0) begin tests_failed++; $display("FAIL scan_second_target: got %0d want 0", target); end
        tests_run++; if (dir_up !== 1'b0) begin tests_failed++; $display("FAIL scan_second_dir: got %b want 0", dir_up); end
        tests_run++; if (state_dbg !== MOVE_DOWN) begin tests_failed++; $display("FAIL scan_state_down: got %0d want MOVE_DOWN", state_dbg); end
        floor = 2'd2;
        step(1);
        floor = 2'd1;
        step(1);
        floor = 2'd0;
        step(1);
        tests_run++; if (stop !== 1'b1) begin tests_failed++; $display("FAIL scan_stop_f0: got %b want 1", stop); end
        step(3);
        tests_run++; if (served_count !== 8'd2) begin tests_failed++; $display("FAIL scan_served: got %0d want 2", served_count); end
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL scan_idle: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_retarget();
        do_reset();
        call = 4'b1000;
        step(1);
        call = '0;
        step(1);
        floor = 2'd1;
        call  = 4'b0100;
        step(1);
        call = '0;
        tests_run++; if (target !== 2'd3) begin tests_failed++; $display("FAIL retarget_before: got %0d want 3", target); end
        tests_run++; if (pending !== 4'b1100) begin tests_failed++; $display("FAIL retarget_pending: got %b want 1100", pending); end
        step(1);
        tests_run++; if (target !== 2'd2) begin tests_failed++; $display("FAIL retarget_after: got %0d want 2", target); end
        floor = 2'd2;
        step(1);
        tests_run++; if (stop !== 1'b1) begin tests_failed++; $display("FAIL retarget_stop2: got %b want 1", stop); end
        tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL retarget_pending2: got %b want 1000", pending); end
        step(3);
        tests_run++; if (target !== 2'd3) begin tests_failed++; $display("FAIL retarget_resume: got %0d want 3", target); end
        tests_run++; if (state_dbg !== MOVE_UP) begin tests_failed++; $display("FAIL retarget_state: got %0d want MOVE_UP", state_dbg); end
        tests_run++; if (stop !== 1'b0) begin tests_failed++; $display("FAIL retarget_stop_drop: got %b want 0", stop); end
        floor = 2'd3;
        step(1);
        tests_run++; if (served_count !== 8'd2) begin tests_failed++; $display("FAIL retarget_served: got %0d want 2", served_count); end
    endtask

    task automatic test_call_here();
        do_reset();
        floor = 2'd2;
        call  = 4'b0100;
        step(1);
        tests_run++; if (pending !== 4'b0100) begin tests_failed++; $display("FAIL here_pending: got %b want 0100", pending); end
        tests_run++; if (stop !== 1'b0) begin tests_failed++; $display("FAIL here_stop_early: got %b want 0", stop); end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            tests_run++; if (stop !== 1'b1) begin tests_failed++; $display("FAIL here_stop_cycle%0d: got %b want 1", k, stop); end
            tests_run++; if (target !== 2'd2) begin tests_failed++; $display("FAIL here_target_cycle%0d: got %0d want 2", k, target); end
            tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL here_masked_cycle%0d: got %b want 0000", k, pending); end
        end
        step(1);
        call = '0;
        tests_run++; if (stop !== 1'b0) begin tests_failed++; $display("FAIL here_stop_drop: got %b want 0", stop); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL here_pending_exit: got %b want 0000", pending); end
        tests_run++; if (served_count !== 8'd1) begin tests_failed++; $display("FAIL here_served: got %0d want 1", served_count); end
        step(1);
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL here_idle: got %0d want IDLE", state_dbg); end
        tests_run++; if (served_count !== 8'd1) begin tests_failed++; $display("FAIL here_served_hold: got %0d want 1", served_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        floor = 2'd1;
        call  = 4'b1010;
        step(1);
        call = '0;
        step(1);
        tests_run++; if (stop !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_stop: got %b want 1", stop); end
        tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL areset_pre_pending: got %b want 1000", pending); end
        reset = 1'b1;
        #2;
        tests_run++; if (stop !== 1'b0) begin tests_failed++; $display("FAIL areset_stop: got %b want 0", stop); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL areset_pending: got %b want 0000", pending); end
        tests_run++; if (served_count !== 8'd0) begin tests_failed++; $display("FAIL areset_served: got %0d want 0", served_count); end
        tests_run++; if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL areset_state: got %0d want IDLE", state_dbg); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL areset_busy: got %b want 0", busy); end
        step(1);
        reset = 1'b0;
        step(1);
        tests_run++; if (target !== 2'd1) begin tests_failed++; $display("FAIL areset_release_target: got %0d want 1", target); end
        tests_run++; if (stop !== 1'b0) begin tests_failed++; $display("FAIL areset_release_stop: got %b want 0", stop); end
    endtask

    task automatic test_back_to_back();
        int rises;
        int exp;
        logic prev_stop;
        do_reset();
        floor = 2'd2;
        call  = 4'b0100;
        rises = 0;
        for (int cyc = 0; cyc < 3000 && rises < 300; cyc++) begin
            prev_stop = stop;
            step(1);
            if (stop && !prev_stop) begin
                rises++;
                exp = (rises > 255) ? 255 : rises;
                tests_run++; if (served_count !== 8'(exp)) begin tests_failed++; $display("FAIL b2b_served_at_%0d: got %0d want %0d", rises, served_count, exp); end
            end
        end
        call = '0;
        tests_run++; if (rises < 300) begin tests_failed++; $display("FAIL b2b_budget: got %0d serves want 300", rises); end
        tests_run++; if (served_count !== 8'd255) begin tests_failed++; $display("FAIL b2b_saturate: got %0d want 255", served_count); end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan_order();
        test_retarget();
        test_call_here();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
